// File: rtl/accel_dispatch_pkg.sv
// Shared definitions for the accelerator dispatch slice: engine indices,
// per-engine FSM state encoding and the default RUN timeout.
package accel_pkg;

   localparam int unsigned ENG_H   = 0;
   localparam int unsigned ENG_E   = 1;
   localparam int unsigned ENG_D   = 2;
   localparam int unsigned NUM_ENG = 3;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } eng_state_t;

endpackage

// File: rtl/accel_dispatch_rr_arbiter.sv
// Round-robin arbiter for the shared data-memory port. The grant is
// registered, held while the granted requester keeps asking, and followed
// by one idle cycle before the next grant. The pointer moves to the
// requester after the one just released.
module rr_arbiter #(
   parameter int unsigned NUM_ENG = accel_pkg::NUM_ENG
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_ENG-1:0] req,
   output logic [NUM_ENG-1:0] gnt
);

   localparam int unsigned PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      gnt_idx;
   logic [PW-1:0]      nxt_ptr;
   logic [NUM_ENG-1:0] pick;
   logic               found;

   // Rotating search from ptr, and encoding of the current grant for the pointer update
   always_comb begin
      pick    = '0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int unsigned j = 0; j < NUM_ENG; j++) begin
         for (int unsigned k = 0; k < NUM_ENG; k++) begin
            if (!found && req[k] && (((32'(ptr) + j) % NUM_ENG) == k)) begin
               pick[k] = 1'b1;
               found   = 1'b1;
            end
         end
      end
      for (int unsigned k = 0; k < NUM_ENG; k++) begin
         if (gnt[k]) gnt_idx = PW'(k);
      end
      nxt_ptr = PW'((32'(gnt_idx) + 1) % NUM_ENG);
   end

   // Grant register: hold, release into an idle cycle, or issue a new grant
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt <= '0;
         ptr <= '0;
      end else if (|gnt) begin
         if (!(|(gnt & req))) begin
            gnt <= '0;
            ptr <= nxt_ptr;
         end
      end else begin
         gnt <= pick;
      end
   end

endmodule

// File: rtl/accel_dispatch.sv
// Accelerator dispatch: accepts hash/encrypt/decrypt start requests from
// decode, sequences one IDLE/START/RUN FSM per engine, keeps sticky
// completion flags and arbitrates the shared data-memory port.
// Optional feature macro: ACCEL_TIMEOUT_EN (per-engine RUN timeout abort).
module accel_dispatch
   import accel_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         h_int,
   input  logic         e_int,
   input  logic         d_int,
   input  logic [10:0]  offset,
   input  logic         h_done,
   input  logic         e_done,
   input  logic         d_done,
   input  logic [2:0]   mem_req,
   input  logic [2:0]   irq_clr,
   output logic [2:0]   start,
   output logic [10:0]  start_offset,
   output logic         stall,
   output logic [2:0]   busy,
   output logic [2:0]   mem_gnt,
   output logic [2:0]   done_irq,
   output logic [2:0]   timeout_err
);

   eng_state_t         state [NUM_ENG];
   logic [NUM_ENG-1:0] req;
   logic [NUM_ENG-1:0] done;
   logic [NUM_ENG-1:0] idle;
   logic [NUM_ENG-1:0] run;
   logic [NUM_ENG-1:0] elig;
   logic [NUM_ENG-1:0] acc;
   logic [NUM_ENG-1:0] tmo;

   // Gather requests/dones by engine index and decode FSM status
   always_comb begin
      req          = '0;
      done         = '0;
      idle         = '0;
      run          = '0;
      req[ENG_H]   = h_int;
      req[ENG_E]   = e_int;
      req[ENG_D]   = d_int;
      done[ENG_H]  = h_done;
      done[ENG_E]  = e_done;
      done[ENG_D]  = d_done;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
         idle[i] = (state[i] == IDLE);
         run[i]  = (state[i] == RUN);
      end
   end

   // Highest-priority request whose engine is idle wins; bit 0 (H) is highest
   assign elig  = req & idle;
   assign acc   = elig & (~elig + 1'b1);
   assign stall = !rst && (|(req & ~acc));
   assign busy  = ~idle;

   // Per-engine FSMs with registered start pulse, offset and completion flags
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_ENG; i++) state[i] <= IDLE;
         start        <= '0;
         start_offset <= '0;
         done_irq     <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_ENG; i++) begin
            case (state[i])
               IDLE:    if (acc[i]) state[i] <= START;
               START:   state[i] <= RUN;
               RUN:     if (done[i] || tmo[i]) state[i] <= IDLE;
               default: state[i] <= IDLE;
            endcase
         end
         start <= acc;
         if (|acc) start_offset <= offset;
         done_irq <= (done & run) | (done_irq & ~irq_clr);
      end
   end

`ifdef ACCEL_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0]   cnt [NUM_ENG];
   logic [NUM_ENG-1:0] tmo_err;

   // A done pulse in the final RUN cycle completes normally rather than aborting
   always_comb begin
      tmo = '0;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
         tmo[i] = run[i] && !done[i] && (32'(cnt[i]) == TIMEOUT_CYCLES - 1);
      end
   end

   // RUN-cycle counters and sticky abort flags
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_ENG; i++) cnt[i] <= '0;
         tmo_err <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_ENG; i++) begin
            cnt[i] <= (run[i] && !done[i] && !tmo[i]) ? cnt[i] + 1'b1 : '0;
         end
         tmo_err <= tmo | (tmo_err & ~irq_clr);
      end
   end

   assign timeout_err = tmo_err;
`else
   assign tmo         = '0;
   assign timeout_err = '0;
`endif

   rr_arbiter #(
      .NUM_ENG (NUM_ENG)
   ) u_arb (
      .clk (clk),
      .rst (rst),
      .req (mem_req),
      .gnt (mem_gnt)
   );

endmodule

// File: tb/tb_accel_dispatch.sv
// Directed self-checking bench for accel_dispatch. Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
module tb_accel_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic        h_int, e_int, d_int;
   logic [10:0] offset;
   logic        h_done, e_done, d_done;
   logic [2:0]  mem_req;
   logic [2:0]  irq_clr;
   logic [2:0]  start;
   logic [10:0] start_offset;
   logic        stall;
   logic [2:0]  busy;
   logic [2:0]  mem_gnt;
   logic [2:0]  done_irq;
   logic [2:0]  timeout_err;

   int tests = 0;
   int fails = 0;

   accel_dispatch #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .h_int        (h_int),
      .e_int        (e_int),
      .d_int        (d_int),
      .offset       (offset),
      .h_done       (h_done),
      .e_done       (e_done),
      .d_done       (d_done),
      .mem_req      (mem_req),
      .irq_clr      (irq_clr),
      .start        (start),
      .start_offset (start_offset),
      .stall        (stall),
      .busy         (busy),
      .mem_gnt      (mem_gnt),
      .done_irq     (done_irq),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [2:0] arb_exp [12];

   initial begin
      arb_exp = '{3'b001, 3'b001, 3'b001, 3'b000,
                  3'b010, 3'b010, 3'b010, 3'b000,
                  3'b100, 3'b100, 3'b100, 3'b000};

      rst = 1'b1; h_int = 1'b0; e_int = 1'b0; d_int = 1'b0; offset = '0;
      h_done = 1'b0; e_done = 1'b0; d_done = 1'b0; mem_req = '0; irq_clr = '0;

      // Reset state, stall suppressed while rst high
      tick();
      h_int = 1'b1;
      #1 chk("rst_stall", 32'(stall), 32'd0);
      tick();
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_offset", 32'(start_offset), 32'd0);
      chk("rst_gnt", 32'(mem_gnt), 32'd0);
      chk("rst_irq", 32'(done_irq), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      h_int = 1'b0;
      rst = 1'b0;
      tick();

      // Encrypt request at cycle N, done at N+6
      e_int = 1'b1; offset = 11'h2A5;
      #1 chk("e_req_stall", 32'(stall), 32'd0);
      tick();
      e_int = 1'b0; offset = '0;
      chk("e_start", 32'(start), 32'b010);
      chk("e_start_offset", 32'(start_offset), 32'h2A5);
      chk("e_busy", 32'(busy), 32'b010);
      tick();
      chk("e_start_low", 32'(start), 32'd0);
      repeat (4) tick();
      chk("e_busy_run", 32'(busy), 32'b010);
      e_done = 1'b1;
      tick();
      e_done = 1'b0;
      chk("e_busy_done", 32'(busy), 32'd0);
      chk("e_irq", 32'(done_irq), 32'b010);
      irq_clr = 3'b010;
      tick();
      irq_clr = '0;
      chk("e_irq_clr", 32'(done_irq), 32'd0);

      // Simultaneous H and D: H first, D next cycle
      h_int = 1'b1; d_int = 1'b1;
      #1 chk("hd_stall", 32'(stall), 32'd1);
      tick();
      chk("hd_start_h", 32'(start), 32'b001);
      h_int = 1'b0;
      #1 chk("d_stall", 32'(stall), 32'd0);
      tick();
      d_int = 1'b0;
      chk("hd_start_d", 32'(start), 32'b100);
      chk("hd_busy", 32'(busy), 32'b101);

      // Request to a running H stalls, including the done cycle
      h_int = 1'b1;
      #1 chk("h_run_stall1", 32'(stall), 32'd1);
      tick();
      chk("h_run_stall2", 32'(stall), 32'd1);
      h_done = 1'b1;
      #1 chk("h_done_stall", 32'(stall), 32'd1);
      tick();
      h_done = 1'b0;
      chk("h_idle_busy", 32'(busy), 32'b100);
      chk("h_irq", 32'(done_irq), 32'b001);
      chk("h_reaccept_stall", 32'(stall), 32'd0);
      chk("h_no_start_yet", 32'(start), 32'd0);
      irq_clr = 3'b001;
      tick();
      h_int = 1'b0; irq_clr = '0;
      chk("h_restart", 32'(start), 32'b001);
      chk("h_irq_cleared", 32'(done_irq), 32'd0);

      // Done in START is ignored; set wins over clear
      h_done = 1'b1;
      tick();
      h_done = 1'b0;
      chk("start_done_busy", 32'(busy), 32'b101);
      chk("start_done_irq", 32'(done_irq), 32'd0);
      h_done = 1'b1; irq_clr = 3'b001;
      tick();
      h_done = 1'b0; irq_clr = '0;
      chk("set_wins_irq", 32'(done_irq), 32'b001);
      chk("set_wins_busy", 32'(busy), 32'b100);
      d_done = 1'b1;
      tick();
      d_done = 1'b0;
      chk("d_done_busy", 32'(busy), 32'd0);
      chk("d_done_irq", 32'(done_irq), 32'b101);
      irq_clr = 3'b111;
      tick();
      irq_clr = '0;
      chk("irq_clr_all", 32'(done_irq), 32'd0);
      d_done = 1'b1;
      tick();
      d_done = 1'b0;
      chk("idle_done_ignored", 32'(done_irq), 32'd0);

      // Round-robin over a held 3'b111, each released after three grant cycles
      mem_req = 3'b111;
      #1 chk("arb_reg_delay", 32'(mem_gnt), 32'd0);
      for (int t = 0; t < 12; t++) begin
         tick();
         chk($sformatf("arb_gnt_t%0d", t + 1), 32'(mem_gnt), 32'(arb_exp[t]));
         chk($sformatf("arb_onehot_t%0d", t + 1), 32'($countones(mem_gnt) <= 1), 32'd1);
         if (t == 2)  mem_req[0] = 1'b0;
         if (t == 6)  mem_req[1] = 1'b0;
         if (t == 10) mem_req[2] = 1'b0;
      end

      // Reset while E runs abandons it; later e_done is stale
      mem_req = 3'b010; e_int = 1'b1; offset = 11'h155;
      tick();
      e_int = 1'b0; offset = '0;
      tick();
      chk("pre_rst_busy", 32'(busy), 32'b010);
      chk("pre_rst_gnt", 32'(mem_gnt), 32'b010);
      chk("pre_rst_offset", 32'(start_offset), 32'h155);
      rst = 1'b1;
      tick();
      chk("mid_rst_start", 32'(start), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_gnt", 32'(mem_gnt), 32'd0);
      chk("mid_rst_offset", 32'(start_offset), 32'd0);
      chk("mid_rst_irq", 32'(done_irq), 32'd0);
      rst = 1'b0; mem_req = '0;
      tick();
      e_done = 1'b1;
      tick();
      e_done = 1'b0;
      chk("stale_done_irq", 32'(done_irq), 32'd0);
      chk("stale_done_busy", 32'(busy), 32'd0);

      // D with no d_done: abort after 8 RUN cycles when the timeout is built in
      d_int = 1'b1;
      tick();
      d_int = 1'b0;
      chk("tmo_start", 32'(start), 32'b100);
      tick();
      repeat (7) tick();
      chk("tmo_busy_8th", 32'(busy), 32'b100);
      tick();
`ifdef ACCEL_TIMEOUT_EN
      chk("tmo_busy_drop", 32'(busy), 32'd0);
      chk("tmo_err_set", 32'(timeout_err), 32'b100);
      chk("tmo_no_irq", 32'(done_irq), 32'd0);
      irq_clr = 3'b100;
      tick();
      irq_clr = '0;
      chk("tmo_err_clr", 32'(timeout_err), 32'd0);
`else
      chk("no_tmo_busy", 32'(busy), 32'b100);
      chk("no_tmo_err", 32'(timeout_err), 32'd0);
      d_done = 1'b1;
      tick();
      d_done = 1'b0;
      chk("no_tmo_done_busy", 32'(busy), 32'd0);
      chk("no_tmo_done_irq", 32'(done_irq), 32'b100);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
